// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//
// Purpose:
//   Serial sequence detector with a runtime-programmable pattern of 1..MAX_LEN
//   bits. Bits are taken from sequence_in only on cycles where in_valid is high.
//   Detection can be overlapping or non-overlapping. The match pulse can be
//   Mealy (same cycle as the last pattern bit) or Moore (one cycle later).
//   A saturating counter tracks the number of matches.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   sequence_in  in   serial data bit
//   in_valid     in   qualifies sequence_in
//   cfg_load     in   one-cycle strobe; latches the cfg_* fields
//   cfg_pattern  in   [MAX_LEN] pattern; bit len-1 is received first, bit 0 last
//   cfg_len      in   [LEN_W] pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//   cfg_overlap  in   1 = overlapping detection, 0 = non-overlapping
//   cfg_moore    in   1 = registered (Moore) output, 0 = Mealy output
//   detector_out out  match pulse
//   match_count  out  [CNT_W] saturating match count
//   count_sat    out  match_count is all-ones
// ---------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 LEN_W           = 4,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1011,
    parameter int                 DEFAULT_LEN     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_moore,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam logic [LEN_W-1:0] MAX_LEN_L     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEFAULT_LEN_L = LEN_W'(DEFAULT_LEN);

    // Configuration registers
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic               r_moore;

    // Only the newest MAX_LEN-1 received bits are stored; together with the
    // incoming bit they form a full MAX_LEN window, so the oldest bit of a
    // MAX_LEN history would never be looked at.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_mooreOut;
    logic [CNT_W-1:0]   r_count;
    logic               r_countSat;

    logic [LEN_W-1:0]   w_cfgLen;
    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_fillOk;
    logic               w_hit;
    logic [CNT_W-1:0]   w_countNext;
    logic [LEN_W-1:0]   w_fillNext;

    // Length legalisation applied at load time so the datapath never sees
    // a length of zero or one longer than the history can cover.
    always_comb begin
        w_cfgLen = cfg_len;
        if (cfg_len == '0) begin
            w_cfgLen = LEN_W'(1);
        end else if (cfg_len > MAX_LEN_L) begin
            w_cfgLen = MAX_LEN_L;
        end
    end

    // Mask of the active pattern bits; bits at or above len are ignored.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    // Candidate window is the stored history with the current bit appended
    // as the newest (bit 0). A hit needs len-1 earlier bits already received,
    // which for len=1 is always true since r_len is never zero.
    always_comb begin
        w_window    = {r_hist, sequence_in};
        w_fillOk    = (r_fill >= (r_len - LEN_W'(1)));
        w_hit       = in_valid && !cfg_load && w_fillOk &&
                      (((w_window ^ r_pattern) & w_mask) == '0);
        w_countNext = (r_count == '1) ? r_count : r_count + CNT_W'(1);
        w_fillNext  = (r_fill >= r_len) ? r_len : r_fill + LEN_W'(1);
    end

    // Output select. Reset low forces the pulse off even on the Mealy path.
    always_comb begin
        detector_out = 1'b0;
        if (reset) begin
            detector_out = r_moore ? r_mooreOut : w_hit;
        end
    end

    assign match_count = r_count;
    assign count_sat   = r_countSat;

    // Configuration latch: only reset and cfg_load change these.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pattern <= DEFAULT_PATTERN;
            r_len     <= DEFAULT_LEN_L;
            r_overlap <= 1'b1;
            r_moore   <= 1'b0;
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_cfgLen;
            r_overlap <= cfg_overlap;
            r_moore   <= cfg_moore;
        end
    end

    // History, fill, Moore register and counter. cfg_load wins over a
    // valid bit in the same cycle and wipes all detection state. A
    // non-overlapping hit wipes the history so the next match needs len
    // fresh bits.
    always_ff @(posedge clock) begin
        if (!reset || cfg_load) begin
            r_hist     <= '0;
            r_fill     <= '0;
            r_mooreOut <= 1'b0;
            r_count    <= '0;
            r_countSat <= 1'b0;
        end else begin
            r_mooreOut <= w_hit;
            if (w_hit) begin
                r_count    <= w_countNext;
                r_countSat <= &w_countNext;
            end
            if (w_hit && !r_overlap) begin
                r_hist <= '0;
                r_fill <= '0;
            end else if (in_valid) begin
                r_hist <= w_window[MAX_LEN-2:0];
                r_fill <= w_fillNext;
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//
// Purpose:
//   Self-checking bench for seq_detector_param (CNT_W=2 so saturation is
//   reachable). A driver applies one cycle of stimulus at a time, computes
//   the expected outputs from a queue-of-bits reference model, and pushes
//   them into a scoreboard queue. A monitor pops and compares on every
//   falling edge.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clock;
    logic               reset;
    logic               sequence_in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cfg_moore;
    logic               detector_out;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;

    seq_detector_param #(
        .MAX_LEN        (MAX_LEN),
        .LEN_W          (LEN_W),
        .CNT_W          (CNT_W),
        .DEFAULT_PATTERN(8'b0000_1011),
        .DEFAULT_LEN    (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sequence_in (sequence_in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cfg_moore   (cfg_moore),
        .detector_out(detector_out),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    typedef struct {
        logic             expOut;
        logic [CNT_W-1:0] expCnt;
        logic             expSat;
        bit               cntKnown;
        string            tag;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 0;

    // Reference model: received bits as a plain queue, oldest first.
    bit         mHq[$];
    int         mLen;
    logic [7:0] mPat;
    bit         mOvl;
    bit         mMoore;
    bit         mMooreReg;
    int         mCount;
    bit         mKnown = 0;

    // 10 time-unit clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One cycle of stimulus: drive inputs after the rising edge, predict the
    // outputs seen before the next edge, then advance the model.
    task automatic applyStimulus(input bit rstN, input bit vld, input bit b,
                                 input bit ld, input string tag);
        bit   hit;
        exp_t e;
        int   legal;
        @(posedge clock);
        #1;
        reset       = rstN;
        in_valid    = vld;
        sequence_in = b;
        cfg_load    = ld;

        hit = 1'b0;
        if (rstN && vld && !ld && (mHq.size() + 1 >= mLen)) begin
            bit cand[$];
            cand = mHq;
            cand.push_back(b);
            hit = 1'b1;
            for (int k = 0; k < mLen; k++) begin
                if (cand[cand.size() - mLen + k] != mPat[mLen - 1 - k]) hit = 1'b0;
            end
        end

        e.expOut   = !rstN ? 1'b0 : (mMoore ? mMooreReg : hit);
        e.expCnt   = CNT_W'(mCount);
        e.expSat   = (mCount == CNT_MAX);
        e.cntKnown = mKnown;
        e.tag      = tag;
        expQ.push_back(e);

        if (!rstN) begin
            mPat = 8'b0000_1011; mLen = 4; mOvl = 1; mMoore = 0;
            mHq.delete(); mMooreReg = 0; mCount = 0; mKnown = 1;
        end else if (ld) begin
            legal = int'(cfg_len);
            if (legal == 0) legal = 1;
            if (legal > MAX_LEN) legal = MAX_LEN;
            mPat = cfg_pattern; mLen = legal; mOvl = cfg_overlap; mMoore = cfg_moore;
            mHq.delete(); mMooreReg = 0; mCount = 0;
        end else begin
            mMooreReg = hit;
            if (hit && mCount < CNT_MAX) mCount++;
            if (hit && !mOvl) begin
                mHq.delete();
            end else if (vld) begin
                mHq.push_back(b);
                if (mHq.size() > MAX_LEN) void'(mHq.pop_front());
            end
        end
    endtask

    task automatic sendBits(input string bits, input string tag);
        for (int i = 0; i < bits.len(); i++) begin
            applyStimulus(1, 1, bits[i] == "1", 0, tag);
        end
    endtask

    task automatic loadCfg(input logic [7:0] p, input logic [3:0] l, input bit o,
                           input bit m, input bit vld, input bit b, input string tag);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        cfg_moore   = m;
        applyStimulus(1, vld, b, 1, tag);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (detector_out !== e.expOut) begin
            failures++;
            $display("[TB] FAIL %s detector_out: got %b expected %b at %0t",
                     e.tag, detector_out, e.expOut, $time);
        end
        if (e.cntKnown) begin
            checks++;
            if (match_count !== e.expCnt) begin
                failures++;
                $display("[TB] FAIL %s match_count: got %0d expected %0d at %0t",
                         e.tag, match_count, e.expCnt, $time);
            end
            checks++;
            if (count_sat !== e.expSat) begin
                failures++;
                $display("[TB] FAIL %s count_sat: got %b expected %b at %0t",
                         e.tag, count_sat, e.expSat, $time);
            end
        end
    endtask

    // Monitor: every falling edge the DUT presents one cycle of outputs.
    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    // Stimulus
    initial begin
        reset = 0; in_valid = 0; sequence_in = 0; cfg_load = 0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_moore = 0;

        applyStimulus(0, 0, 0, 0, "reset");
        applyStimulus(0, 1, 1, 0, "reset");

        sendBits("1011011", "default_ovl_mealy");

        loadCfg(8'b1011, 4, 0, 0, 0, 0, "load_novl");
        sendBits("1011011", "novl_mealy");

        loadCfg(8'b1011, 4, 1, 1, 0, 0, "load_moore");
        sendBits("1011", "moore");
        applyStimulus(1, 0, 1, 0, "moore_after");
        applyStimulus(1, 0, 1, 0, "moore_after");
        sendBits("1011011", "moore_b2b");

        loadCfg(8'b0011_0110, 6, 1, 0, 0, 0, "load_len6");
        sendBits("110110110", "len6");
        loadCfg(8'b1111_1101, 0, 1, 0, 0, 0, "load_len0");
        sendBits("1101001", "len0");
        loadCfg(8'b1010_0101, 12, 1, 0, 0, 0, "load_len12");
        sendBits("1010010110100101", "len12");

        loadCfg(8'b1011, 4, 1, 0, 0, 0, "load_gap");
        sendBits("10", "gap");
        repeat (3) applyStimulus(1, 0, 1, 0, "gap_idle");
        sendBits("11", "gap");
        sendBits("101", "load_collide");
        loadCfg(8'b1011, 4, 1, 0, 1, 1, "load_collide");
        sendBits("1011", "after_collide");

        loadCfg(8'b11, 2, 1, 0, 0, 0, "load_sat");
        sendBits("111111", "saturate");
        loadCfg(8'b1011, 4, 1, 0, 0, 0, "load_midreset");
        sendBits("11011", "midreset_pre");
        sendBits("101", "midreset_pre");
        applyStimulus(0, 1, 1, 0, "midreset_low");
        applyStimulus(0, 1, 1, 0, "midreset_low");
        sendBits("1", "midreset_post");
        sendBits("1011", "midreset_post");

        for (int r = 0; r < 25; r++) begin
            loadCfg(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), "rand_load");
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 59) == 0) begin
                    applyStimulus(0, 1'($urandom), 1'($urandom), 0, "rand_reset");
                end else if ($urandom_range(0, 39) == 0) begin
                    loadCfg(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom),
                            1'($urandom), 1'($urandom), 1'($urandom), "rand_midload");
                end else begin
                    applyStimulus(1, $urandom_range(0, 9) < 8, 1'($urandom), 0, "rand");
                end
            end
        end

        for (int w = 0; w < 4 && expQ.size() > 0; w++) @(negedge clock);
        @(posedge clock);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #1000000;
        if (!done) begin
            failures++;
            $display("[TB] FAIL watchdog: got timeout expected completion");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed-pattern serial sequence detector.
- Detects a runtime-programmable bit pattern of 1..MAX_LEN bits on a serial stream qualified by a valid strobe.
- Selectable overlapping/non-overlapping detection and Mealy/Moore output timing; keeps a saturating match counter.
- Sits on the serial input path and feeds status/interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length field; must hold MAX_LEN
CNT_W, 8, match counter width
DEFAULT_PATTERN, 8'b0000_1011, pattern after reset (LSB-aligned)
DEFAULT_LEN, 4, pattern length after reset

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
sequence_in  in  1  serial data bit
in_valid  in  1  sequence_in is sampled only when high
cfg_load  in  1  one-cycle strobe; latches cfg_* fields
cfg_pattern  in  MAX_LEN  pattern; bit len-1 is the first bit received, bit 0 the last
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
cfg_moore  in  1  1 = registered (Moore) output, 0 = Mealy output
detector_out  out  1  match pulse
match_count  out  CNT_W  number of matches, saturating
count_sat  out  1  match_count has reached all-ones

Behaviour:
- Reset (reset low at a clock edge):
  - pattern=DEFAULT_PATTERN, len=DEFAULT_LEN, overlap=1, moore=0.
  - hist=0, fill=0, moore output register=0, match_count=0, count_sat=0.
  - While reset is low, detector_out is forced to 0, including the Mealy path.
- State:
  - hist[MAX_LEN-1:0] holds received bits, newest at bit 0.
  - fill counts received bits, saturating at len.
- Accepted bit (in_valid=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], sequence_in}.
  - fill <= min(fill+1, len).
  - in_valid=0: hist and fill hold, and no match can occur.
- hit (combinational):
  - in_valid && !cfg_load && fill >= len-1 && {hist[len-2:0], sequence_in} == pattern[len-1:0].
  - len=1: hit = in_valid && sequence_in==pattern[0].
- Mealy (moore=0): detector_out = hit, in the same cycle as the last pattern bit.
- Moore (moore=1): detector_out is a register loaded with hit every cycle.
  - It is high exactly one cycle after the hit cycle.
  - Back-to-back hits give consecutive high cycles.
- Overlap=1: history is retained after a hit.
- Overlap=0: on a hit, fill <= 0 and hist <= 0 in the same edge. The next match needs len fresh bits.
- Counter:
  - On a hit, match_count increments unless it is already all-ones, where it holds.
  - count_sat = (match_count == all-ones), registered alongside the count.
- cfg_load:
  - Latches pattern, len, overlap and moore.
  - Clears hist, fill, match_count, count_sat and the Moore register.
  - Has priority over in_valid in the same cycle: that bit is dropped and no hit is raised.
- Length legalisation at load: cfg_len=0 is stored as 1; cfg_len>MAX_LEN is stored as MAX_LEN.
- Pattern bits above len-1 are ignored in the compare.
- Reset mid-stream: a partially received pattern is discarded. The first match after reset needs len new bits.
- No combinational path from cfg_* to detector_out except through cfg_load gating hit.

Test Plan:
1. Default config (1011, overlap, Mealy). After reset, stream 1,0,1,1,0,1,1 with in_valid=1 every cycle -> detector_out high during bits 4 and 7 only; match_count=2.
2. cfg_load with pattern 1011, len=4, overlap=0, moore=0, then stream 1,0,1,1,0,1,1 -> single pulse at bit 4; match_count=1.
3. Moore mode, len=4, pattern 1011, stream 1,0,1,1 -> detector_out low during bit 4, high exactly the following cycle, low after; also check in_valid deasserted the cycle after the hit.
4. Load pattern 6'b110110, len=6, overlap=1, stream 1,1,0,1,1,0,1,1,0 -> hits at bits 6 and 9. Then cfg_load len=0 and len=12 -> stored len reads back as 1 and 8 (len=1 pattern 1 hits on every valid 1).
5. Gaps: stream 1,0, then 3 cycles in_valid=0 with sequence_in=1, then 1,1 -> one hit, on the final bit. Also cfg_load asserted together with the final valid bit -> no hit, history cleared.
6. CNT_W=2, five matches -> match_count sticks at 3 and count_sat=1 from the third match. Then pull reset low mid-pattern (after 1,0,1) and send 1 -> no hit; match_count=0, count_sat=0, detector_out=0 while reset is low.
